color_cmd_parser: RTL

Upstream feeder for the color register file. Takes the byte stream from the UART receiver and decodes ASCII write frames of the form 'W', address hex digit, data hex digit, CR. Each decoded frame becomes one 4-bit address / 4-bit data write, presented on a valid/ack handshake to the register-file write port. It also reports malformed frames, overruns and ack timeouts.

---
 rtl/color_cmd_parser_if.sv | 22 ++
 rtl/color_cmd_parser.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/color_cmd_parser_if.sv
// Write-request bundle between the UART-facing parser and the color register file.
// master drives the rx byte stream and ack; slave is the parser itself.
interface color_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] address;
  logic [3:0] data;
  logic       valid;
  logic       ack;
  logic       err;
  logic [7:0] cmd_count;

  modport master (
    output rx_data, rx_valid, ack,
    input  address, data, valid, err, cmd_count
  );

  modport slave (
    input  rx_data, rx_valid, ack,
    output address, data, valid, err, cmd_count
  );
endinterface

// File: rtl/color_cmd_parser.sv
// Decodes ASCII "W<addr><data>\r" frames into 4-bit register writes on a valid/ack handshake,
// flagging malformed frames, overruns and ack timeouts with a one-cycle err pulse.
module color_cmd_parser #(
  parameter int unsigned TIMEOUT = 1024
) (
  input logic                clk,
  input logic                rst,
  color_cmd_parser_if.slave  bus
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT - 1);

  localparam logic [7:0] ChW  = 8'h57;
  localparam logic [7:0] ChCr = 8'h0D;

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StGetEnd,
    StWaitAck
  } state_e;

  state_e          state_q;
  logic [3:0]      addr_shadow_q;
  logic [3:0]      data_shadow_q;
  logic [3:0]      address_q;
  logic [3:0]      data_q;
  logic            valid_q;
  logic            err_q;
  logic [7:0]      cmd_count_q;
  logic [CntW-1:0] tmo_cnt_q;

  logic       rx_hex;
  logic [3:0] rx_nibble;

  always_comb begin
    rx_hex    = 1'b0;
    rx_nibble = 4'h0;
    if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
      rx_hex    = 1'b1;
      rx_nibble = bus.rx_data[3:0];
    end else if ((bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) ||
                 (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66)) begin
      // 'A'..'F' and 'a'..'f' share the low nibble 1..6
      rx_hex    = 1'b1;
      rx_nibble = bus.rx_data[3:0] + 4'd9;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      addr_shadow_q <= 4'h0;
      data_shadow_q <= 4'h0;
      address_q     <= 4'h0;
      data_q        <= 4'h0;
      valid_q       <= 1'b0;
      err_q         <= 1'b0;
      cmd_count_q   <= 8'd0;
      tmo_cnt_q     <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.rx_valid && bus.rx_data == ChW) state_q <= StGetAddr;
        end

        StGetAddr: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == ChW) begin
              state_q <= StGetAddr;
            end else if (rx_hex) begin
              addr_shadow_q <= rx_nibble;
              state_q       <= StGetData;
            end else begin
              err_q         <= 1'b1;
              addr_shadow_q <= 4'h0;
              data_shadow_q <= 4'h0;
              state_q       <= StIdle;
            end
          end
        end

        StGetData: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == ChW) begin
              state_q <= StGetAddr;
            end else if (rx_hex) begin
              data_shadow_q <= rx_nibble;
              state_q       <= StGetEnd;
            end else begin
              err_q         <= 1'b1;
              addr_shadow_q <= 4'h0;
              data_shadow_q <= 4'h0;
              state_q       <= StIdle;
            end
          end
        end

        StGetEnd: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == ChW) begin
              state_q <= StGetAddr;
            end else if (bus.rx_data == ChCr) begin
              address_q <= addr_shadow_q;
              data_q    <= data_shadow_q;
              valid_q   <= 1'b1;
              tmo_cnt_q <= '0;
              state_q   <= StWaitAck;
            end else begin
              err_q         <= 1'b1;
              addr_shadow_q <= 4'h0;
              data_shadow_q <= 4'h0;
              state_q       <= StIdle;
            end
          end
        end

        StWaitAck: begin
          // Bytes arriving while a write is outstanding are overruns, never frame starts
          if (bus.rx_valid) err_q <= 1'b1;
          if (bus.ack) begin
            valid_q     <= 1'b0;
            cmd_count_q <= cmd_count_q + 8'd1;
            state_q     <= StIdle;
          end else if (tmo_cnt_q == TmoLast) begin
            valid_q <= 1'b0;
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CntW'(1);
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.address   = address_q;
  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.err       = err_q;
  assign bus.cmd_count = cmd_count_q;

endmodule
